// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared types and constants for the data-memory/IO bus arbiter.
// Used by the arbiter, its address decoder, top-level glue and the bench.
package dmem_bus_pkg;

  localparam int unsigned DMEM_WORDS_DEFAULT = 1024;
  localparam logic [31:0] IO_BASE_DEFAULT    = 32'hFFFF_FFF0;
  // Bits that must match IO_BASE for an address to fall in the 16-word IO window
  localparam logic [31:0] IO_WIN_MASK        = 32'hFFFF_FFF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TGT_MEM  = 2'd0,
    TGT_IO   = 2'd1,
    TGT_NONE = 2'd2
  } target_e;

  // True when addr lies inside the IO window anchored at base
  function automatic logic in_io_window(input logic [31:0] addr, input logic [31:0] base);
    return ((addr & IO_WIN_MASK) == (base & IO_WIN_MASK));
  endfunction

endpackage

// File: rtl/dmem_bus_arbiter_if.sv
// Requester-side bus bundle: one instance per master (M0 = CPU data port,
// M1 = debug/program loader). The requester holds req/we/addr/wdata stable
// until ack; ack/err/rdata come back from the arbiter.
interface dmem_bus_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/dmem_bus_arbiter_addr_decode.sv
// Combinational address classifier: IO window takes precedence, then the
// DataMem range [0, DMEM_WORDS), everything else decodes to no target.
module dmem_addr_decode
  import dmem_bus_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEFAULT,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
  input  logic [31:0] addr,
  output target_e     target
);

  // Classify the word address into MEM, IO or NONE
  always_comb begin
    target = TGT_NONE;
    if (in_io_window(addr, IO_BASE)) begin
      target = TGT_IO;
    end else if (addr < 32'(DMEM_WORDS)) begin
      target = TGT_MEM;
    end else begin
      target = TGT_NONE;
    end
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter for the shared DataMem/iobuffer bus.
// Each transaction occupies IDLE -> ACCESS -> RESP (three cycles): the grant
// and request fields are latched in IDLE, the write strobe is driven for the
// single ACCESS cycle, and the one-cycle ack goes to the winner in RESP.
// Build option: define DMEM_ARB_RR_EN for round-robin tie breaking; without
// it M0 wins every tie.
module dmem_bus_arbiter
  import dmem_bus_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = DMEM_WORDS_DEFAULT,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  dmem_bus_arbiter_if.slave        m0,
  dmem_bus_arbiter_if.slave        m1,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     mem_we,
  input  logic [31:0]              mem_rdata,
  output logic [1:0]               io_addr,
  output logic [31:0]              io_wdata,
  output logic                     io_we,
  input  logic [31:0]              io_rdata,
  output logic                     busy,
  output logic                     gnt_id
);

  state_e      state_r, state_next_s;
  logic        win_s;
  logic [31:0] sel_addr_s, sel_wdata_s;
  logic        sel_we_s;
  target_e     sel_tgt_s;

  logic [31:0] addr_r, addr_next_s;
  logic [31:0] wdata_r, wdata_next_s;
  logic        we_r, we_next_s;
  target_e     tgt_r, tgt_next_s;
  logic        gnt_r, gnt_next_s;
  logic        mem_we_r, mem_we_next_s;
  logic        io_we_r, io_we_next_s;
  logic        m0_ack_r, m0_ack_next_s;
  logic        m1_ack_r, m1_ack_next_s;
  logic        m0_err_r, m0_err_next_s;
  logic        m1_err_r, m1_err_next_s;
  logic        busy_r, busy_next_s;
  logic [31:0] rdata_s, m0_rdata_s, m1_rdata_s;

`ifdef DMEM_ARB_RR_EN
  // Master granted most recently; resets to M1 so M0 wins the first tie
  logic        last_r;
`endif

  // Choose which master would be granted if the FSM grants this cycle
  always_comb begin
    win_s = 1'b0;
    if (m0.req && m1.req) begin
`ifdef DMEM_ARB_RR_EN
      win_s = ~last_r;
`else
      win_s = 1'b0;
`endif
    end else if (m1.req) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  assign sel_addr_s  = win_s ? m1.addr  : m0.addr;
  assign sel_wdata_s = win_s ? m1.wdata : m0.wdata;
  assign sel_we_s    = win_s ? m1.we    : m0.we;

  dmem_addr_decode #(
    .DMEM_WORDS (DMEM_WORDS),
    .IO_BASE    (IO_BASE)
  ) u_decode (
    .addr   (sel_addr_s),
    .target (sel_tgt_s)
  );

  // Next-state and next-output logic; every output below is registered
  always_comb begin
    state_next_s  = state_r;
    addr_next_s   = addr_r;
    wdata_next_s  = wdata_r;
    we_next_s     = we_r;
    tgt_next_s    = tgt_r;
    gnt_next_s    = gnt_r;
    mem_we_next_s = 1'b0;
    io_we_next_s  = 1'b0;
    m0_ack_next_s = 1'b0;
    m1_ack_next_s = 1'b0;
    m0_err_next_s = 1'b0;
    m1_err_next_s = 1'b0;
    busy_next_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (m0.req || m1.req) begin
          state_next_s  = ACCESS;
          addr_next_s   = sel_addr_s;
          wdata_next_s  = sel_wdata_s;
          we_next_s     = sel_we_s;
          tgt_next_s    = sel_tgt_s;
          gnt_next_s    = win_s;
          mem_we_next_s = sel_we_s & (sel_tgt_s == TGT_MEM);
          io_we_next_s  = sel_we_s & (sel_tgt_s == TGT_IO);
          busy_next_s   = 1'b1;
        end else begin
          state_next_s  = IDLE;
        end
      end
      ACCESS: begin
        state_next_s = RESP;
        busy_next_s  = 1'b1;
        if (gnt_r) begin
          m1_ack_next_s = 1'b1;
          m1_err_next_s = (tgt_r == TGT_NONE);
        end else begin
          m0_ack_next_s = 1'b1;
          m0_err_next_s = (tgt_r == TGT_NONE);
        end
      end
      RESP: begin
        // Requests are ignored here; the requester drops req after ack
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State and output registers; async reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      we_r     <= 1'b0;
      tgt_r    <= TGT_NONE;
      gnt_r    <= 1'b0;
      mem_we_r <= 1'b0;
      io_we_r  <= 1'b0;
      m0_ack_r <= 1'b0;
      m1_ack_r <= 1'b0;
      m0_err_r <= 1'b0;
      m1_err_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      addr_r   <= addr_next_s;
      wdata_r  <= wdata_next_s;
      we_r     <= we_next_s;
      tgt_r    <= tgt_next_s;
      gnt_r    <= gnt_next_s;
      mem_we_r <= mem_we_next_s;
      io_we_r  <= io_we_next_s;
      m0_ack_r <= m0_ack_next_s;
      m1_ack_r <= m1_ack_next_s;
      m0_err_r <= m0_err_next_s;
      m1_err_r <= m1_err_next_s;
      busy_r   <= busy_next_s;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Remember the last granted master; moves only when a grant is made
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (state_r == IDLE && (m0.req || m1.req)) begin
      last_r <= win_s;
    end else begin
      last_r <= last_r;
    end
  end
`endif

  // Steer the target's synchronous read data to the winner during RESP
  always_comb begin
    rdata_s    = 32'h0000_0000;
    m0_rdata_s = 32'h0000_0000;
    m1_rdata_s = 32'h0000_0000;
    if (state_r == RESP && !we_r) begin
      case (tgt_r)
        TGT_MEM: rdata_s = mem_rdata;
        TGT_IO:  rdata_s = io_rdata;
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
    if (gnt_r) begin
      m1_rdata_s = rdata_s;
    end else begin
      m0_rdata_s = rdata_s;
    end
  end

  assign m0.ack    = m0_ack_r;
  assign m0.err    = m0_err_r;
  assign m0.rdata  = m0_rdata_s;
  assign m1.ack    = m1_ack_r;
  assign m1.err    = m1_err_r;
  assign m1.rdata  = m1_rdata_s;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_we    = mem_we_r;
  assign io_addr   = addr_r[1:0];
  assign io_wdata  = wdata_r;
  assign io_we     = io_we_r;
  assign busy      = busy_r;
  assign gnt_id    = gnt_r;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Scoreboard bench for dmem_bus_arbiter: drivers push expected strobes and
// responses per master; a negedge monitor pops and compares on ACCESS/ack.
module tb_dmem_bus_arbiter;
  import dmem_bus_pkg::*;

  typedef struct packed {
    logic        mem_we;
    logic        io_we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_bus_arbiter_if m0_if();
  dmem_bus_arbiter_if m1_if();

  logic [31:0] mem_addr, mem_wdata, mem_rdata, io_wdata, io_rdata;
  logic [1:0]  io_addr;
  logic        mem_we, io_we, busy, gnt_id;

  dmem_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_we     (io_we),
    .io_rdata  (io_rdata),
    .busy      (busy),
    .gnt_id    (gnt_id)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_lat = 0;
  acc_t acc_q0[$];
  acc_t acc_q1[$];
  rsp_t rsp_q0[$];
  rsp_t rsp_q1[$];
  int   ack_ids[$];
  int   ack_cyc[$];
  int   exp_order[$];

  logic [31:0] mem_model [0:1023];
  logic [31:0] io_model  [0:3];

  // Synchronous-read DataMem and iobuffer models
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem_model[i] <= 32'h0;
      for (int i = 0; i < 4; i++) io_model[i] <= 32'h0;
      mem_rdata <= 32'h0;
      io_rdata  <= 32'h0;
    end else begin
      if (mem_we && mem_addr < 32'd1024) mem_model[mem_addr[9:0]] <= mem_wdata;
      if (io_we) io_model[io_addr] <= io_wdata;
      mem_rdata <= mem_model[mem_addr[9:0]];
      io_rdata  <= io_model[io_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one transaction on master id, wait for its ack, release req in the IDLE cycle
  task automatic drv(input bit id, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic e_mem_we, input logic e_io_we,
                     input logic e_err, input logic [31:0] e_rdata);
    acc_t a;
    rsp_t r;
    bit   got;
    int   lat;
    a = '{mem_we: e_mem_we, io_we: e_io_we, addr: addr, wdata: wdata};
    r = '{err: e_err, rdata: e_rdata};
    if (id) begin
      acc_q1.push_back(a); rsp_q1.push_back(r);
      m1_if.req = 1'b1; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
    end else begin
      acc_q0.push_back(a); rsp_q0.push_back(r);
      m0_if.req = 1'b1; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
    end
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = id ? m1_if.ack : m0_if.ack;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout_m%0d: got no ack in 40 cycles expected ack", id);
    end
    last_lat = lat;
    @(negedge clk);
    if (id) m1_if.req = 1'b0; else m0_if.req = 1'b0;
  endtask

  // Monitor: ACCESS is the first busy cycle, RESP the second; compare against queues
  initial begin
    logic prev_busy;
    acc_t a;
    rsp_t r;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_busy = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          if ((gnt_id ? acc_q1.size() : acc_q0.size()) == 0) begin
            checks++; failures++;
            $display("FAIL access_unexpected: got access for m%0d expected none", gnt_id);
          end else begin
            a = gnt_id ? acc_q1.pop_front() : acc_q0.pop_front();
            chk("access_we", {mem_we, io_we}, {a.mem_we, a.io_we});
            chk("access_addr", {io_addr, mem_addr}, {a.addr[1:0], a.addr});
            chk("access_wdata", {io_wdata, mem_wdata}, {a.wdata, a.wdata});
          end
        end else begin
          chk("strobe_outside_access", {mem_we, io_we}, 2'b00);
        end
        if (busy && prev_busy) chk("resp_ack", {m1_if.ack, m0_if.ack}, gnt_id ? 2'b10 : 2'b01);
        else chk("stray_ack", {m1_if.ack, m0_if.ack}, 2'b00);
        if (m0_if.ack) begin
          if (rsp_q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected_m0: got ack expected none");
          end else begin
            r = rsp_q0.pop_front();
            chk("m0_err", m0_if.err, r.err);
            chk("m0_rdata", m0_if.rdata, r.rdata);
          end
          ack_ids.push_back(0);
          ack_cyc.push_back(cyc);
        end
        if (m1_if.ack) begin
          if (rsp_q1.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected_m1: got ack expected none");
          end else begin
            r = rsp_q1.pop_front();
            chk("m1_err", m1_if.err, r.err);
            chk("m1_rdata", m1_if.rdata, r.rdata);
          end
          ack_ids.push_back(1);
          ack_cyc.push_back(cyc);
        end
        prev_busy = busy;
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = 32'h0; m0_if.wdata = 32'h0;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = 32'h0; m1_if.wdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err, mem_we, io_we, busy, gnt_id}, 8'h00);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_io_addr", io_addr, 2'b00);
    chk("rst_wdata", {mem_wdata, io_wdata}, 64'h0);
    chk("rst_rdata", {m0_if.rdata, m1_if.rdata}, 64'h0);
    #1 rst = 1'b0;
    @(negedge clk);

    // DataMem write then read back
    drv(1'b0, 1'b1, 32'd5, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("m0_ack_latency", last_lat, 2);
    drv(1'b0, 1'b0, 32'd5, 32'h0, 1'b0, 1'b0, 1'b0, 32'h1234_5678);

    // IO window write and read back from M1
    drv(1'b1, 1'b1, 32'hFFFF_FFF2, 32'h0000_00AB, 1'b0, 1'b1, 1'b0, 32'h0);
    drv(1'b1, 1'b0, 32'hFFFF_FFF2, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0000_00AB);

    // Decode boundaries
    drv(1'b0, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    drv(1'b0, 1'b1, 32'h8000_0000, 32'h55, 1'b0, 1'b0, 1'b1, 32'h0);
    drv(1'b0, 1'b1, 32'd1023, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b0, 1'b0, 32'd1023, 32'h0, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D);
    drv(1'b0, 1'b0, 32'hFFFF_FFEF, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);

    // Simultaneous requests after reset
    @(negedge clk) rst = 1'b1;
    @(negedge clk) #1 rst = 1'b0;
    @(negedge clk);
    ack_ids.delete();
`ifdef DMEM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
    fork
      begin
        drv(1'b0, 1'b1, 32'd16, 32'h10, 1'b1, 1'b0, 1'b0, 32'h0);
        drv(1'b0, 1'b1, 32'd17, 32'h11, 1'b1, 1'b0, 1'b0, 32'h0);
      end
      begin
        drv(1'b1, 1'b1, 32'd32, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0);
        drv(1'b1, 1'b1, 32'd33, 32'h21, 1'b1, 1'b0, 1'b0, 32'h0);
      end
    join
`else
    exp_order = '{0, 0, 0, 0, 1};
    fork
      begin
        for (int i = 0; i < 4; i++)
          drv(1'b0, 1'b1, 32'(16 + i), 32'(32'h10 + i), 1'b1, 1'b0, 1'b0, 32'h0);
      end
      begin
        drv(1'b1, 1'b1, 32'd32, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0);
      end
    join
`endif
    chk("grant_count", ack_ids.size(), exp_order.size());
    for (int i = 0; i < exp_order.size() && i < ack_ids.size(); i++)
      chk($sformatf("grant_order_%0d", i), ack_ids[i], exp_order[i]);

    // Reset during ACCESS of an M1 write
    acc_q1.push_back('{mem_we: 1'b1, io_we: 1'b0, addr: 32'd7, wdata: 32'hDEAD_BEEF});
    m1_if.req = 1'b1; m1_if.we = 1'b1; m1_if.addr = 32'd7; m1_if.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_mem_we", mem_we, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_m1_ack", m1_if.ack, 1'b0);
    @(negedge clk);
    chk("rst_hold_m1_ack", m1_if.ack, 1'b0);
    #1 rst = 1'b0;
    m1_if.req = 1'b0;
    @(negedge clk);
    drv(1'b1, 1'b1, 32'd7, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0);
    drv(1'b0, 1'b0, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);

    // Back-to-back reads: one ack every three cycles
    for (int i = 0; i < 4; i++)
      drv(1'b1, 1'b1, 32'(i), 32'(32'hA0 + i), 1'b1, 1'b0, 1'b0, 32'h0);
    ack_cyc.delete();
    for (int i = 0; i < 4; i++)
      drv(1'b0, 1'b0, 32'(i), 32'h0, 1'b0, 1'b0, 1'b0, 32'(32'hA0 + i));
    chk("b2b_ack_count", ack_cyc.size(), 4);
    for (int i = 0; i + 1 < ack_cyc.size(); i++)
      chk($sformatf("b2b_spacing_%0d", i), ack_cyc[i + 1] - ack_cyc[i], 3);

    repeat (2) @(negedge clk);
    chk("leftover_access", acc_q0.size() + acc_q1.size(), 0);
    chk("leftover_resp", rsp_q0.size() + rsp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
